// File: rtl/fp_mul_issue.sv
// Issue/sequencing stage in front of a combinational binary64 multiplier: operand FIFO,
// settle-window timing, result capture with special-case flags. Optional macro: FP_SPECIAL_OVERRIDE_EN.
module fp_mul_issue #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [63:0]                   in_a,
    input  logic [63:0]                   in_b,
    output logic [63:0]                   mul_a,
    output logic [63:0]                   mul_b,
    input  logic [63:0]                   mul_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [63:0]                   out_result,
    output logic [3:0]                    out_flags,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CNW = PW + 1;
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t        state, state_next;
    logic [63:0]   mem_a [FIFO_DEPTH];
    logic [63:0]   mem_b [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [SW-1:0] counter;
    logic          push, pop, capture, fifo_empty;

    assign in_ready   = (fifo_count != CNW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid && in_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (counter == SW'(1)) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    // back-to-back issue straight from the handshake cycle
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand classification of the issued pair
    logic [10:0] exp_a, exp_b;
    logic [51:0] frac_a, frac_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub;
    logic        f_invalid, f_inf, f_zero, f_sub;
    logic [63:0] result_sel;

    assign exp_a  = mul_a[62:52];
    assign exp_b  = mul_b[62:52];
    assign frac_a = mul_a[51:0];
    assign frac_b = mul_b[51:0];
    assign a_nan  = (exp_a == 11'h7FF) && (frac_a != '0);
    assign b_nan  = (exp_b == 11'h7FF) && (frac_b != '0);
    assign a_inf  = (exp_a == 11'h7FF) && (frac_a == '0);
    assign b_inf  = (exp_b == 11'h7FF) && (frac_b == '0);
    assign a_zero = (exp_a == 11'h000) && (frac_a == '0);
    assign b_zero = (exp_b == 11'h000) && (frac_b == '0);
    assign a_sub  = (exp_a == 11'h000) && (frac_a != '0);
    assign b_sub  = (exp_b == 11'h000) && (frac_b != '0);

    assign f_invalid = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
    assign f_inf     = (a_inf || b_inf) && !f_invalid;
    assign f_zero    = (a_zero || b_zero) && !f_invalid;
    assign f_sub     = a_sub || b_sub;

`ifdef FP_SPECIAL_OVERRIDE_EN
    logic sign_p;
    assign sign_p = mul_a[63] ^ mul_b[63];
    always_comb begin
        result_sel = mul_result;
        if (f_invalid)   result_sel = 64'h7FF8_0000_0000_0000;
        else if (f_inf)  result_sel = {sign_p, 11'h7FF, 52'h0};
        else if (f_zero) result_sel = {sign_p, 63'h0};
    end
`else
    assign result_sel = mul_result;
`endif

    // Storage array carries no reset; only pointers/count define occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            counter    <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNW'(1);
                2'b01:   fifo_count <= fifo_count - CNW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop) begin
                mul_a   <= mem_a[rd_ptr];
                mul_b   <= mem_b[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
                counter <= SW'(SETTLE_CYCLES);
            end else if (state == ISSUE) begin
                counter <= counter - SW'(1);
            end
            if (capture) begin
                out_result <= result_sel;
                out_flags  <= {f_invalid, f_inf, f_zero, f_sub};
                out_valid  <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_issue.sv
// Scoreboard bench for fp_mul_issue: behavioural multiplier on the mul_* port, reference
// model on accepted operand pairs, decoupled monitor comparing every presented result.
module tb_fp_mul_issue;

    localparam int FD = 4;
    localparam int S  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] mul_a, mul_b, mul_result, out_result;
    logic [3:0]  out_flags;
    logic [$clog2(FD):0] fifo_count;

    fp_mul_issue #(.FIFO_DEPTH(FD), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // stand-in for the combinational multiplier
    always_comb mul_result = fmul(mul_a, mul_b);

    // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 nan
    function automatic int cls(input logic [63:0] x);
        if (x[62:52] == 11'h7FF) return (x[51:0] == 0) ? 3 : 4;
        if (x[62:52] == 11'h000) return (x[51:0] == 0) ? 0 : 1;
        return 2;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b);
        int  ca, cb;
        logic inv;
        ca  = cls(a);
        cb  = cls(b);
        inv = (ca == 4) || (cb == 4) || (ca == 0 && cb == 3) || (ca == 3 && cb == 0);
        return {inv, (ca == 3 || cb == 3) && !inv, (ca == 0 || cb == 0) && !inv, (ca == 1 || cb == 1)};
    endfunction

    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b);
`ifdef FP_SPECIAL_OVERRIDE_EN
        logic [3:0] f;
        logic       s;
        f = ref_flags(a, b);
        s = a[63] ^ b[63];
        if (f[3]) return 64'h7FF8000000000000;
        if (f[2]) return {s, 11'h7FF, 52'h0};
        if (f[1]) return {s, 63'h0};
`endif
        return fmul(a, b);
    endfunction

    function automatic logic [63:0] rand_fp();
        logic [63:0] x;
        x = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: x[62:0] = '0;
            1: x[62:0] = {11'h7FF, 52'h0};
            2: begin x[62:52] = 11'h7FF; x[0] = 1'b1; end
            3: begin x[62:52] = 11'h000; x[0] = 1'b1; end
            default: x[62:52] = 11'($urandom_range(1, 2046));
        endcase
        return x;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_val  = '0;

    // Monitor: decides at negedge which handshakes the next rising edge will complete
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_result", out_result, hold_val);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_result);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", out_result, e.r);
                    chk("sb_flags", out_flags, e.f);
                end
            end
            if (in_valid && in_ready)
                sbq.push_back('{r: ref_result(in_a, in_b), f: ref_flags(in_a, in_b)});
            hold_pend = out_valid && !out_ready;
            hold_val  = out_result;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 1000; i++) begin
            if (!busy && !out_valid) return;
            tick();
        end
        chk({nm, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (out_valid) return;
            tick();
        end
        chk({nm, "_valid_timeout"}, out_valid, 1'b1);
    endtask

    task automatic run_single(input string nm, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] er, input bit cr, input logic [3:0] ef);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        tick();
        in_valid = 1'b0;
        repeat (S + 1) begin
            chk({nm, "_early"}, out_valid, 1'b0);
            tick();
        end
        chk({nm, "_valid"}, out_valid, 1'b1);
        if (cr) chk({nm, "_result"}, out_result, er);
        chk({nm, "_flags"}, out_flags, ef);
        tick();
        wait_idle(nm);
    endtask

    logic [63:0] pa[7], pb[7];
    int          idx, n0;
    logic        rdy;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_busy", busy, 1'b0);

        run_single("mul_3x2p5", 64'h4008000000000000, 64'h4004000000000000, 64'h401E000000000000, 1'b1, 4'b0000);
        run_single("neg1x0", 64'hBFF0000000000000, 64'h0000000000000000, 64'h8000000000000000, 1'b1, 4'b0010);
`ifdef FP_SPECIAL_OVERRIDE_EN
        run_single("infx0", 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 1'b1, 4'b1000);
`else
        run_single("infx0", 64'h7FF0000000000000, 64'h0000000000000000, 64'h0, 1'b0, 4'b1000);
`endif
        run_single("minnorm", 64'h0010000000000000, 64'h4000000000000000, 64'h0020000000000000, 1'b1, 4'b0000);
        run_single("subnorm", 64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000002, 1'b1, 4'b0001);

        // backpressure: 7 distinct pairs offered, only issue slot + FIFO can take them
        for (int i = 0; i < 7; i++) begin
            pa[i] = $realtobits(1.0 + i);
            pb[i] = $realtobits(2.0 + 0.5 * i);
        end
        out_ready = 1'b0;
        n0  = n_out;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 7);
            if (idx < 7) begin
                in_a = pa[idx];
                in_b = pb[idx];
            end
            rdy = in_ready;
            tick();
            if (rdy && idx < 7) idx++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", idx, 5);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_count", fifo_count, FD);
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        wait_idle("bp_drain");
        chk("bp_outputs", n_out - n0, 5);

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = rand_fp();
            in_b      = rand_fp();
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("rand_drain");
        chk("rand_sb_empty", sbq.size(), 0);

        // reset while the first of three queued pairs is in ISSUE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = $realtobits(5.0);
        in_b      = $realtobits(3.0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_a = pa[i];
            in_b = pb[i];
            tick();
        end
        in_valid = 1'b0;
        wait_valid("rst_mid");
        chk("rst_mid_count", fifo_count, 3);
        out_ready = 1'b1;
        tick();
        chk("rst_mid_issued", mul_a, pa[0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_count0", fifo_count, 0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_mul_a", mul_a, 0);
        chk("rst_mid_mul_b", mul_b, 0);
        n0 = n_out;
        repeat (10) tick();
        chk("rst_mid_no_stale", n_out - n0, 0);
        chk("rst_mid_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
